// File: rtl/reduce_pkg.sv
// Shared types and helpers for the pipelined lane reducer.
package reduce_pkg;

  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_NAND = 2'b11
  } reduce_op_e;

  // Per-bit identity; callers replicate it across the lane width.
  function automatic logic identity(reduce_op_e op);
    return (op == OP_AND) || (op == OP_NAND);
  endfunction

  // NAND reduces as AND; the inversion is applied once, at the output.
  function automatic logic combine(reduce_op_e op, logic a, logic b);
    case (op)
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      default: return a & b;
    endcase
  endfunction

  function automatic int num_stages(int num, int reg_every);
    int levels;
    levels = $clog2(num);
    if (num <= 1 || reg_every <= 0) return 0;
    return (levels + reg_every - 1) / reg_every;
  endfunction

endpackage

// File: rtl/reduce_level.sv
// One tree level: pairwise-combines N_IN lanes into N_IN/2, optionally behind
// a valid/ready register stage.
module reduce_level
  import reduce_pkg::*;
#(
  parameter int N_IN  = 2,
  parameter int WIDTH = 64,
  parameter int REG   = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [N_IN*WIDTH-1:0]     in_data,
  input  logic [1:0]                in_op,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [N_IN/2*WIDTH-1:0]   out_data,
  output logic [1:0]                out_op,
  output logic                      out_last
);

  localparam int N_OUT = N_IN / 2;

  logic [N_OUT*WIDTH-1:0] red;

  always_comb begin
    red = '0;
    for (int i = 0; i < N_OUT; i++) begin
      for (int b = 0; b < WIDTH; b++) begin
        red[i*WIDTH+b] = combine(reduce_op_e'(in_op),
                                 in_data[2*i*WIDTH+b],
                                 in_data[(2*i+1)*WIDTH+b]);
      end
    end
  end

  if (REG != 0) begin : g_reg
    logic                   valid_q, valid_d;
    logic                   last_q, last_d;
    logic [1:0]             op_q, op_d;
    logic [N_OUT*WIDTH-1:0] data_q, data_d;
    logic                   adv;

    assign adv = !valid_q || out_ready;

    always_comb begin
      valid_d = adv ? in_valid : valid_q;
      data_d  = data_q;
      op_d    = op_q;
      last_d  = last_q;
      if (adv && in_valid) begin
        data_d = red;
        op_d   = in_op;
        last_d = in_last;
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        data_q  <= '0;
        op_q    <= '0;
        last_q  <= 1'b0;
      end else begin
        valid_q <= valid_d;
        data_q  <= data_d;
        op_q    <= op_d;
        last_q  <= last_d;
      end
    end

    assign in_ready  = adv;
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_op    = op_q;
    assign out_last  = last_q;
  end else begin : g_comb
    logic unused_clk_rst;
    assign unused_clk_rst = clk & rst_n;

    assign in_ready  = out_ready;
    assign out_valid = in_valid;
    assign out_data  = red;
    assign out_op    = in_op;
    assign out_last  = in_last;
  end

endmodule

// File: rtl/axi_reduce_pipe.sv
// Pipelined NUM-lane bitwise reducer with per-lane mask and optional
// multi-beat folding into one result per packet.
module axi_reduce_pipe
  import reduce_pkg::*;
#(
  parameter int NUM       = 8,
  parameter int WIDTH     = 64,
  parameter int REG_EVERY = 1,
  parameter int ACCUM     = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NUM*WIDTH-1:0] in_data,
  input  logic [NUM-1:0]       in_mask,
  input  logic [1:0]           in_op,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data
);

  localparam int LEVELS = $clog2(NUM);
  localparam int P      = 1 << LEVELS;
  localparam int RE     = (REG_EVERY > 0) ? REG_EVERY : 1;

  logic             first_q, first_d;
  logic [1:0]       op_q, op_d;
  logic [1:0]       op_cur;
  logic             src_last, src_ready, accept, id_bit;
  logic [P*WIDTH-1:0] lanes;

  assign op_cur   = first_q ? in_op : op_q;
  assign src_last = (ACCUM == 0) ? 1'b1 : in_last;
  assign in_ready = src_ready & rst_n;
  assign accept   = in_valid & in_ready;
  assign id_bit   = identity(reduce_op_e'(op_cur));

  always_comb begin
    first_d = first_q;
    op_d    = op_q;
    if (accept) begin
      if (first_q) op_d = in_op;
      first_d = src_last;
    end
  end

  // Masked lanes and power-of-two padding both take the operator identity.
  for (genvar i = 0; i < P; i++) begin : g_lane
    if (i < NUM) begin : g_real
      assign lanes[i*WIDTH +: WIDTH] = in_mask[i] ? in_data[i*WIDTH +: WIDTH]
                                                  : {WIDTH{id_bit}};
    end else begin : g_pad
      assign lanes[i*WIDTH +: WIDTH] = {WIDTH{id_bit}};
    end
  end

  logic             acc_rdy;
  logic [WIDTH-1:0] tail_dat;
  logic [1:0]       tail_op;
  logic             tail_vld, tail_lst;

  // Level 0 is the masked input; level l is the output of the l-th halving.
  for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
    localparam int NL = P >> l;
    logic [NL*WIDTH-1:0] dat;
    logic [1:0]          op;
    logic                vld, lst, rdy_up, rdy_dn;

    if (l == 0) begin : g_src
      assign dat    = lanes;
      assign vld    = in_valid;
      assign op     = op_cur;
      assign lst    = src_last;
      assign rdy_up = rdy_dn;
    end else begin : g_red
      localparam int REG_L = ((REG_EVERY > 0) && ((l % RE) == 0 || l == LEVELS)) ? 1 : 0;
      reduce_level #(.N_IN(2*NL), .WIDTH(WIDTH), .REG(REG_L)) u_level (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (g_lvl[l-1].vld),
        .in_ready  (rdy_up),
        .in_data   (g_lvl[l-1].dat),
        .in_op     (g_lvl[l-1].op),
        .in_last   (g_lvl[l-1].lst),
        .out_valid (vld),
        .out_ready (rdy_dn),
        .out_data  (dat),
        .out_op    (op),
        .out_last  (lst)
      );
    end

    if (l == LEVELS) begin : g_tail
      assign rdy_dn = acc_rdy;
    end else begin : g_link
      assign rdy_dn = g_lvl[l+1].rdy_up;
    end
  end

  assign src_ready = g_lvl[0].rdy_up;
  assign tail_dat  = g_lvl[LEVELS].dat;
  assign tail_op   = g_lvl[LEVELS].op;
  assign tail_vld  = g_lvl[LEVELS].vld;
  assign tail_lst  = g_lvl[LEVELS].lst;

  logic [WIDTH-1:0] acc_q, acc_d, out_data_q, out_data_d, folded;
  logic             acc_active_q, acc_active_d, out_valid_q, out_valid_d, take;
  reduce_op_e       tail_op_e;

  assign tail_op_e = reduce_op_e'(tail_op);
  assign acc_rdy   = !out_valid_q || out_ready;
  assign take      = acc_rdy && tail_vld;

  always_comb begin
    folded = tail_dat;
    if (acc_active_q) begin
      for (int b = 0; b < WIDTH; b++) folded[b] = combine(tail_op_e, acc_q[b], tail_dat[b]);
    end
  end

  always_comb begin
    acc_d        = acc_q;
    acc_active_d = acc_active_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    if (take) begin
      acc_d = folded;
      if (tail_lst) begin
        out_valid_d  = 1'b1;
        out_data_d   = (tail_op_e == OP_NAND) ? ~folded : folded;
        acc_active_d = 1'b0;
      end else begin
        acc_active_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      first_q      <= 1'b1;
      op_q         <= '0;
      acc_q        <= '0;
      acc_active_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
    end else begin
      first_q      <= first_d;
      op_q         <= op_d;
      acc_q        <= acc_d;
      acc_active_q <= acc_active_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_axi_reduce_pipe.sv
// Directed bench: three reducer configurations driven with hand-computed vectors.
module tb_axi_reduce_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic out_ready = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // A: ACCUM=0, B: ACCUM=1 (both NUM=8, REG_EVERY=1); C: NUM=5, REG_EVERY=2.
  logic [511:0] ab_data = '0;
  logic [7:0]   ab_mask = '0;
  logic [1:0]   ab_op = '0;
  logic         ab_last = 1'b0;
  logic         a_valid = 1'b0, b_valid = 1'b0;
  logic         a_ready, b_ready, a_ovalid, b_ovalid;
  logic [63:0]  a_odata, b_odata;

  logic [319:0] c_data = '0;
  logic [4:0]   c_mask = '0;
  logic [1:0]   c_op = '0;
  logic         c_last = 1'b0;
  logic         c_valid = 1'b0;
  logic         c_ready, c_ovalid;
  logic [63:0]  c_odata;

  axi_reduce_pipe #(.NUM(8), .WIDTH(64), .REG_EVERY(1), .ACCUM(0)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_valid), .in_ready(a_ready),
    .in_data(ab_data), .in_mask(ab_mask), .in_op(ab_op), .in_last(ab_last),
    .out_valid(a_ovalid), .out_ready(out_ready), .out_data(a_odata));

  axi_reduce_pipe #(.NUM(8), .WIDTH(64), .REG_EVERY(1), .ACCUM(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_valid), .in_ready(b_ready),
    .in_data(ab_data), .in_mask(ab_mask), .in_op(ab_op), .in_last(ab_last),
    .out_valid(b_ovalid), .out_ready(out_ready), .out_data(b_odata));

  axi_reduce_pipe #(.NUM(5), .WIDTH(64), .REG_EVERY(2), .ACCUM(1)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(c_valid), .in_ready(c_ready),
    .in_data(c_data), .in_mask(c_mask), .in_op(c_op), .in_last(c_last),
    .out_valid(c_ovalid), .out_ready(out_ready), .out_data(c_odata));

  logic [63:0] qa_d[$], qb_d[$], qc_d[$];
  int          qa_t[$], qb_t[$], qc_t[$];

  always @(negedge clk) begin
    if (rst_n && out_ready) begin
      if (a_ovalid) begin qa_d.push_back(a_odata); qa_t.push_back(cyc); end
      if (b_ovalid) begin qb_d.push_back(b_odata); qb_t.push_back(cyc); end
      if (c_ovalid) begin qc_d.push_back(c_odata); qc_t.push_back(cyc); end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Presents one beat to instance sel and waits (bounded) for its handshake.
  task automatic send(input int sel, input logic [1:0] op, input logic last, output int t_acc);
    int  n;
    logic rdy;
    n = 0;
    t_acc = -1;
    ab_op = op; c_op = op; ab_last = last; c_last = last;
    a_valid = (sel == 0); b_valid = (sel == 1); c_valid = (sel == 2);
    while (t_acc < 0 && n < 100) begin
      @(negedge clk);
      rdy = (sel == 0) ? a_ready : (sel == 1) ? b_ready : c_ready;
      if (rdy) t_acc = cyc;
      n++;
      @(posedge clk);
      #1;
    end
    a_valid = 1'b0; b_valid = 1'b0; c_valid = 1'b0;
    check("send_accept", 64'(t_acc >= 0), 64'd1);
  endtask

  // Expects exactly one result from instance sel, then clears its queue.
  task automatic expect_one(input string tag, input int sel, input logic [63:0] exp,
                            input int t_acc, input int lat);
    int          sz, tt;
    logic [63:0] d;
    case (sel)
      0: begin sz = qa_d.size(); d = (sz > 0) ? qa_d[0] : '1; tt = (sz > 0) ? qa_t[0] : -1;
               qa_d.delete(); qa_t.delete(); end
      1: begin sz = qb_d.size(); d = (sz > 0) ? qb_d[0] : '1; tt = (sz > 0) ? qb_t[0] : -1;
               qb_d.delete(); qb_t.delete(); end
      default: begin sz = qc_d.size(); d = (sz > 0) ? qc_d[0] : '1; tt = (sz > 0) ? qc_t[0] : -1;
               qc_d.delete(); qc_t.delete(); end
    endcase
    check({tag, "_count"}, 64'(sz), 64'd1);
    check({tag, "_data"}, d, exp);
    if (lat >= 0) check({tag, "_lat"}, 64'(tt - t_acc), 64'(lat));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, k, n;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready_a", 64'(a_ready), 64'd0);
    check("rst_in_ready_c", 64'(c_ready), 64'd0);
    check("rst_out_valid_a", 64'(a_ovalid), 64'd0);
    check("rst_out_data_b", b_odata, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready_a", 64'(a_ready), 64'd1);
    @(posedge clk); #1;

    // Single-beat reductions on A; in_last held low to show it is ignored.
    ab_data = '1; ab_data[5*64 +: 64] = 64'h0F0F_0F0F_0F0F_0F0F; ab_mask = 8'hFF;
    send(0, 2'b00, 1'b0, t); idle(8);
    expect_one("and_lane5", 0, 64'h0F0F_0F0F_0F0F_0F0F, t, 4);

    ab_data = '1; ab_data[63:0] = 64'h1; ab_mask = 8'h01;
    send(0, 2'b01, 1'b0, t); idle(8);
    expect_one("or_mask01", 0, 64'h1, t, 4);

    ab_mask = 8'h00;
    send(0, 2'b11, 1'b0, t); idle(8);
    expect_one("nand_all_masked", 0, 64'h0, t, -1);

    send(0, 2'b00, 1'b0, t); idle(8);
    expect_one("and_all_masked", 0, 64'hFFFF_FFFF_FFFF_FFFF, t, -1);

    for (int i = 0; i < 8; i++) ab_data[i*64 +: 64] = 64'(i + 1);
    ab_mask = 8'hFF;
    send(0, 2'b10, 1'b0, t); idle(8);
    expect_one("xor_1to8", 0, 64'h8, t, -1);

    ab_data = '1; ab_data[3*64 +: 64] = 64'hF0;
    send(0, 2'b11, 1'b0, t); idle(8);
    expect_one("nand_lane3", 0, 64'hFFFF_FFFF_FFFF_FF0F, t, -1);

    // Multi-beat folding on B; mid-packet op changes must be ignored.
    ab_data = '0; ab_mask = 8'hFF;
    ab_data[63:0] = 64'h3; send(1, 2'b10, 1'b0, t);
    ab_data[63:0] = 64'h5; send(1, 2'b00, 1'b0, t);
    ab_data[63:0] = 64'h6; send(1, 2'b00, 1'b1, t); idle(8);
    expect_one("accum_xor_356", 1, 64'h0, t, 4);

    ab_data[63:0] = 64'h7; send(1, 2'b10, 1'b0, t);
    ab_data[63:0] = 64'h3; send(1, 2'b00, 1'b0, t);
    ab_data[63:0] = 64'h1; send(1, 2'b00, 1'b1, t); idle(8);
    expect_one("accum_xor_731", 1, 64'h5, t, 4);

    ab_data = '1; ab_mask = 8'h01;
    ab_data[63:0] = 64'hF; send(1, 2'b11, 1'b0, t);
    ab_data[63:0] = 64'hE; send(1, 2'b01, 1'b0, t);
    ab_data[63:0] = 64'hC; send(1, 2'b01, 1'b1, t); idle(8);
    expect_one("accum_nand", 1, 64'hFFFF_FFFF_FFFF_FFF3, t, 4);

    // Backpressure on A: out_ready low for 10 cycles under continuous in_valid.
    out_ready = 1'b0;
    k = 0;
    ab_data = '0; ab_data[63:0] = 64'h1000; ab_mask = 8'hFF; ab_op = 2'b01; ab_last = 1'b1;
    a_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (a_ready) k++;
      @(posedge clk); #1;
      ab_data[63:0] = 64'h1000 + 64'(k);
    end
    @(negedge clk);
    check("bp_accepted", 64'(k), 64'd4);
    check("bp_in_ready", 64'(a_ready), 64'd0);
    check("bp_hold_valid", 64'(a_ovalid), 64'd1);
    check("bp_hold_data", a_odata, 64'h1000);
    check("bp_no_drain", 64'(qa_d.size()), 64'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    n = 0;
    while (k < 8 && n < 100) begin
      @(negedge clk);
      if (a_ready) k++;
      @(posedge clk); #1;
      ab_data[63:0] = 64'h1000 + 64'(k);
      if (k == 8) a_valid = 1'b0;
      n++;
    end
    a_valid = 1'b0;
    idle(10);
    check("bp_count", 64'(qa_d.size()), 64'd8);
    for (int i = 0; i < 8; i++)
      check($sformatf("bp_order%0d", i), (i < qa_d.size()) ? qa_d[i] : '1, 64'h1000 + 64'(i));
    qa_d.delete(); qa_t.delete();

    // Reset in the middle of a 4-beat packet on B: one beat folded, one in flight.
    ab_data = '1; ab_mask = 8'h01;
    ab_data[63:0] = 64'h3; send(1, 2'b00, 1'b0, t); idle(6);
    ab_data[63:0] = 64'h7; send(1, 2'b00, 1'b0, t);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid_in_ready", 64'(b_ready), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    ab_data = '0; ab_data[63:0] = 64'h8; ab_mask = 8'hFF;
    send(1, 2'b01, 1'b1, t); idle(8);
    expect_one("post_rst_or", 1, 64'h8, t, 4);

    // NUM=5, REG_EVERY=2 on C: padding and latency 3.
    c_data = {64'hF, 64'h8, 64'hC, 64'hE, 64'hF}; c_mask = 5'h1F;
    send(2, 2'b00, 1'b1, t); idle(8);
    expect_one("c_and", 2, 64'h8, t, 3);

    c_mask = 5'b10111;
    send(2, 2'b00, 1'b1, t); idle(8);
    expect_one("c_and_mask3", 2, 64'hC, t, 3);

    c_data = {64'h10, 64'h8, 64'h4, 64'h2, 64'h1}; c_mask = 5'h1F;
    send(2, 2'b10, 1'b1, t); idle(8);
    expect_one("c_xor", 2, 64'h1F, t, -1);

    c_data = '0; c_data[4*64 +: 64] = 64'h10;
    send(2, 2'b01, 1'b1, t); idle(8);
    expect_one("c_or_lane4", 2, 64'h10, t, -1);

    c_data = '1; c_data[4*64 +: 64] = 64'hF0;
    send(2, 2'b11, 1'b1, t); idle(8);
    expect_one("c_nand_lane4", 2, 64'hFFFF_FFFF_FFFF_FF0F, t, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_reduce_pipe.md
Name: axi_reduce_pipe

Overview:
Pipelined, handshaked successor to the crossbar's combinational N-input bitwise reducer. It reduces NUM lanes of WIDTH bits with a per-packet operator (AND/OR/XOR/NAND) and honours a per-lane mask. It can also fold successive beats into one result per packet. It sits in the AXI4 crossbar on response and arbitration merge paths, where wide combinational reductions break timing.

Parameters:
NUM, 8, number of input lanes (>=1; non-power-of-two padded with operator identity)
WIDTH, 64, bits per lane
REG_EVERY, 1, tree levels between pipeline registers; 0 = fully combinational tree
ACCUM, 1, 1 = fold beats until in_last; 0 = every beat is its own packet (in_last ignored)

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
in_valid  input  1  input beat valid
in_ready  output  1  input beat accepted when in_valid & in_ready
in_data  input  NUM*WIDTH  lane i at bits [i*WIDTH +: WIDTH]
in_mask  input  NUM  1 = lane participates; 0 = lane replaced by identity
in_op  input  2  00 AND, 01 OR, 10 XOR, 11 NAND; sampled on first beat of packet only
in_last  input  1  final beat of packet
out_valid  output  1  result valid
out_ready  input  1  result consumed when out_valid & out_ready
out_data  output  WIDTH  packet result

Behaviour:
- Identity: all-ones for AND/NAND, zero for OR/XOR. It is applied to masked lanes and pad lanes.
- Tree: LEVELS = clog2(NUM). STAGES = 0 if NUM==1 or REG_EVERY==0, else ceil(LEVELS/REG_EVERY). A register follows every REG_EVERY levels, counted from the inputs.
- NAND: the tree and accumulator compute AND; the result is inverted only when loaded into out_data.
- Op latch: an input-side first flag is set at reset and after an accepted in_last beat. in_op is captured on an accepted beat while first=1. The captured op travels with the data through all stages. in_op changes mid-packet are ignored.
- Pipeline: each stage k holds valid_k. A stage advances when !valid_k or the downstream stage advances. The final downstream is the accumulator/output stage.
- in_ready is the advance condition of stage 0. It is combinational from downstream state and out_ready, with no dependence on in_valid. in_ready is 0 while rst_n is low.
- Accumulator/output stage accepts a beat when !out_valid or out_ready. On accept:
  - If acc_active=0, acc <= beat. Otherwise acc <= acc op beat.
  - If last (or ACCUM=0), out_data <= final(acc op beat), out_valid <= 1, acc_active <= 0. Otherwise acc_active <= 1.
- Latency: with out_ready=1, a last beat accepted at cycle t gives out_valid=1 at t+STAGES+1. Throughput is one beat per cycle with no bubbles under continuous ready.
- Backpressure: out_valid holds and out_data is stable until the handshake. Stages fill, then in_ready drops. No beat is lost or duplicated.
- Simultaneous drain and accept in the same cycle is allowed: out_valid stays 1 with new data.
- All lanes masked: the result is the identity (AND all-ones, NAND zero).
- Reset (sync, rst_n=0 at a clk edge): all valid_k=0, acc_active=0, acc=0, out_valid=0, out_data=0, first=1. Reset mid-packet discards the partial accumulation and in-flight beats.
- out_data and out_valid are registered. There is no combinational path from in_* to out_*.

Decomposition:
- Package reduce_pkg:
  - reduce_op_e enum (OP_AND, OP_OR, OP_XOR, OP_NAND)
  - function identity(op, WIDTH)
  - function combine(op, a, b), where NAND maps to AND
  - function num_stages(NUM, REG_EVERY)
- Sub-module reduce_level: one tree level halving the lane count, with an optional register and valid/ready stage. It is instantiated per level via generate.

Test Plan:
- NUM=8, AND, mask=FF, ACCUM=0; lanes all FFFF_FFFF_FFFF_FFFF except lane5=0F0F_..._0F0F; accept at t -> out_data 0F0F_..._0F0F at t+4.
- OR, mask=0x01, lane0=0x1, other lanes=~0 -> out_data 0x1. NAND, mask=0x00 -> out_data 0.
- ACCUM=1, XOR, 3 beats (lane0 = 0x3, 0x5, 0x6, other lanes 0), in_op switched to AND on beats 2-3 -> single out_data 0x0, out_valid for exactly one cycle.
- out_ready=0 for 10 cycles under continuous in_valid -> in_ready falls after STAGES+1 beats are accepted; results emerge in order with no loss or duplication after release.
- rst_n low for one cycle mid-packet (after 2 of 4 beats), then a fresh 1-beat OR packet of 0x8 -> out_data 0x8, with no residue from the aborted packet.
- NUM=5, REG_EVERY=2, AND with lanes 0xF,0xE,0xC,0x8,0xF -> out_data 0x8 at latency 3 (ceil(3/2)+1).
